// File: rtl/jogo_defs_pkg.sv
// Shared definitions for the move-detection logic: FSM state codes and debug helpers.
package jogo_defs_pkg;

    typedef enum logic [2:0] {
        StEspera      = 3'd0,
        StFiltra      = 3'd1,
        StPulso       = 3'd2,
        StSolta       = 3'd3,
        StFiltraSolta = 3'd4
    } estado_e;

    localparam logic [3:0] DbErro = 4'hF;

    // Debug code shown on db_estado; unused encodings are flagged as an error.
    function automatic logic [3:0] codigo_db(input estado_e st);
        case (st)
            StEspera, StFiltra, StPulso, StSolta, StFiltraSolta: return {1'b0, st};
            default: return DbErro;
        endcase
    endfunction

    // True when more than one bit is set (clearing the lowest set bit leaves something).
    function automatic logic mais_de_um_bit(input logic [31:0] v);
        return (v & (v - 32'd1)) != 32'd0;
    endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, one chain per bit.
module sincronizador_2ff #(
    parameter int unsigned Largura = 1
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic [Largura-1:0] d_i,
    output logic [Largura-1:0] q_o
);

    logic [Largura-1:0] meta_q;
    logic [Largura-1:0] sinc_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            meta_q <= '0;
            sinc_q <= '0;
        end else begin
            meta_q <= d_i;
            sinc_q <= meta_q;
        end
    end

    assign q_o = sinc_q;

endmodule

// File: rtl/detector_jogada_debounce.sv
// Turns raw player buttons into a single-cycle debounced move pulse plus the registered code,
// with a flag for illegal multi-button presses.
module detector_jogada_debounce
    import jogo_defs_pkg::*;
#(
    parameter int unsigned NBotoes        = 4,
    parameter int unsigned DebounceCiclos = 5000
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic [NBotoes-1:0] botoes_i,
    input  logic               habilita_i,
    input  logic               zera_i,
    output logic               jogada_o,
    output logic [NBotoes-1:0] botoes_reg_o,
    output logic               multipla_o,
    output logic [3:0]         db_estado_o
);

    localparam int unsigned    CntW   = $clog2(DebounceCiclos);
    localparam logic [CntW-1:0] CntMax = CntW'(DebounceCiclos - 1);

    logic [NBotoes-1:0] s;

    sincronizador_2ff #(
        .Largura (NBotoes)
    ) u_sinc_botoes (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .d_i     (botoes_i),
        .q_o     (s)
    );

    estado_e            estado_q, estado_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [NBotoes-1:0] amostra_q, amostra_d;
    logic               jogada_q;
    logic [NBotoes-1:0] botoes_reg_q;
    logic               multipla_q;
    logic [3:0]         db_estado_q;

    always_comb begin
        estado_d  = estado_q;
        cnt_d     = cnt_q;
        amostra_d = amostra_q;
        case (estado_q)
            StEspera: begin
                if (habilita_i && (s != '0)) begin
                    estado_d  = StFiltra;
                    amostra_d = s;
                end
            end
            StFiltra: begin
                if ((s != amostra_q) || !habilita_i) begin
                    estado_d = StEspera;
                end else if (cnt_q == CntMax) begin
                    estado_d = StPulso;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StPulso: begin
                estado_d = StSolta;
            end
            StSolta: begin
                if (s == '0) begin
                    estado_d = StFiltraSolta;
                end
            end
            StFiltraSolta: begin
                if (s != '0) begin
                    estado_d = StSolta;
                end else if (cnt_q == CntMax) begin
                    estado_d = StEspera;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                estado_d = StEspera;
            end
        endcase
        // Every state entry starts a fresh stability window.
        if (estado_d != estado_q) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            estado_q     <= StEspera;
            cnt_q        <= '0;
            amostra_q    <= '0;
            jogada_q     <= 1'b0;
            botoes_reg_q <= '0;
            multipla_q   <= 1'b0;
            db_estado_q  <= 4'h0;
        end else begin
            estado_q    <= estado_d;
            cnt_q       <= cnt_d;
            amostra_q   <= amostra_d;
            jogada_q    <= (estado_q == StPulso);
            db_estado_q <= codigo_db(estado_q);
            // A pulse beats a simultaneous clear so the freshly accepted code is kept.
            if (estado_q == StPulso) begin
                botoes_reg_q <= amostra_q;
                multipla_q   <= mais_de_um_bit(32'(amostra_q));
            end else if (zera_i) begin
                botoes_reg_q <= '0;
                multipla_q   <= 1'b0;
            end
        end
    end

    assign jogada_o     = jogada_q;
    assign botoes_reg_o = botoes_reg_q;
    assign multipla_o   = multipla_q;
    assign db_estado_o  = db_estado_q;

endmodule

// File: tb/tb_detector_jogada_debounce.sv
// Randomized and directed bench for detector_jogada_debounce against a run-length press/release model.
module tb_detector_jogada_debounce;

    localparam int D = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       habilita;
    logic       zera;
    logic [3:0] botoes;
    logic       jogada;
    logic [3:0] botoes_reg;
    logic       multipla;
    logic [3:0] db_estado;

    always #5 clock = ~clock;

    detector_jogada_debounce #(
        .NBotoes        (4),
        .DebounceCiclos (D)
    ) dut (
        .clock_i      (clock),
        .reset_i      (reset),
        .botoes_i     (botoes),
        .habilita_i   (habilita),
        .zera_i       (zera),
        .jogada_o     (jogada),
        .botoes_reg_o (botoes_reg),
        .multipla_o   (multipla),
        .db_estado_o  (db_estado)
    );

    int n_checks = 0;
    int n_errors = 0;
    int pulses = 0;
    int cyc = 0;
    int last_pulse_cyc = 0;
    logic [3:0] db_trace[$];

    // Model: press phase needs D+1 consecutive enabled equal nonzero samples, release phase
    // needs D+1 consecutive zero samples; a broken run discards the breaking sample.
    bit         m_release = 0;
    bit         m_pulse = 0;
    int         m_run = 0;
    logic [3:0] m_val = 4'h0;
    logic [3:0] dly0 = 4'h0;
    logic [3:0] dly1 = 4'h0;
    logic       exp_jog = 1'b0;
    logic [3:0] exp_reg = 4'h0;
    logic       exp_mul = 1'b0;
    logic [3:0] exp_db = 4'h0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [3:0] m_code();
        if (m_pulse) return 4'd2;
        if (!m_release) return (m_run > 0) ? 4'd1 : 4'd0;
        return (m_run > 0) ? 4'd4 : 4'd3;
    endfunction

    function automatic void m_advance(input logic [3:0] s, input logic h);
        if (m_pulse) begin
            m_pulse   = 0;
            m_release = 1;
            m_run     = 0;
        end else if (!m_release) begin
            if (m_run == 0) begin
                if (h && s != 4'h0) begin
                    m_run = 1;
                    m_val = s;
                end
            end else if (h && s == m_val) begin
                m_run++;
                if (m_run == D + 1) begin
                    m_pulse = 1;
                    m_run   = 0;
                end
            end else begin
                m_run = 0;
            end
        end else begin
            if (m_run == 0) begin
                if (s == 4'h0) m_run = 1;
            end else if (s == 4'h0) begin
                m_run++;
                if (m_run == D + 1) begin
                    m_release = 0;
                    m_run     = 0;
                end
            end else begin
                m_run = 0;
            end
        end
    endfunction

    task automatic step(input logic [3:0] b, input logic h, input logic z, input logic r);
        botoes   = b;
        habilita = h;
        zera     = z;
        reset    = r;
        if (r) begin
            exp_jog   = 1'b0;
            exp_reg   = 4'h0;
            exp_mul   = 1'b0;
            exp_db    = 4'h0;
            m_release = 0;
            m_pulse   = 0;
            m_run     = 0;
            m_val     = 4'h0;
            dly0      = 4'h0;
            dly1      = 4'h0;
        end else begin
            exp_jog = m_pulse;
            if (m_pulse) begin
                exp_reg = m_val;
                exp_mul = ($countones(m_val) > 1);
            end else if (z) begin
                exp_reg = 4'h0;
                exp_mul = 1'b0;
            end
            exp_db = m_code();
            m_advance(dly1, h);
            dly1 = dly0;
            dly0 = b;
        end
        @(posedge clock);
        #1;
        cyc++;
        check_eq("jogada", 32'(jogada), 32'(exp_jog));
        check_eq("botoes_reg", 32'(botoes_reg), 32'(exp_reg));
        check_eq("multipla", 32'(multipla), 32'(exp_mul));
        check_eq("db_estado", 32'(db_estado), 32'(exp_db));
        if (jogada === 1'b1) begin
            pulses++;
            last_pulse_cyc = cyc;
        end
        if (db_trace.size() == 0 || db_trace[$] != db_estado) db_trace.push_back(db_estado);
    endtask

    task automatic hold(input logic [3:0] b, input logic h, input int n);
        for (int i = 0; i < n; i++) step(b, h, 1'b0, 1'b0);
    endtask

    int         c0;
    logic [3:0] rb;
    logic       rh;
    int         rlen;

    initial begin
        botoes = 4'h0; habilita = 1'b0; zera = 1'b0; reset = 1'b1;
        for (int i = 0; i < 3; i++) step(4'h0, 1'b1, 1'b0, 1'b1);
        check_eq("reset_db", 32'(db_estado), 32'h0);
        check_eq("reset_reg", 32'(botoes_reg), 32'h0);

        // 1: clean press, latency and state sequence
        pulses = 0; db_trace.delete(); c0 = cyc;
        hold(4'b0010, 1'b1, 20);
        check_eq("t1_pulses", 32'(pulses), 32'd1);
        check_eq("t1_latency", 32'(last_pulse_cyc - c0 - 1), 32'd7);
        check_eq("t1_reg", 32'(botoes_reg), 32'b0010);
        check_eq("t1_mul", 32'(multipla), 32'd0);
        check_eq("t1_seq_len", 32'(db_trace.size()), 32'd4);
        for (int i = 0; i < 4 && i < db_trace.size(); i++)
            check_eq("t1_seq", 32'(db_trace[i]), 32'(i));
        hold(4'h0, 1'b1, 10);

        // 2: short glitch
        pulses = 0;
        hold(4'b0100, 1'b1, 3);
        hold(4'h0, 1'b1, 8);
        check_eq("t2_pulses", 32'(pulses), 32'd0);
        check_eq("t2_db", 32'(db_estado), 32'd0);
        check_eq("t2_reg", 32'(botoes_reg), 32'b0010);

        // 3: multi-button press
        pulses = 0;
        hold(4'b1001, 1'b1, 12);
        check_eq("t3_pulses", 32'(pulses), 32'd1);
        check_eq("t3_reg", 32'(botoes_reg), 32'b1001);
        check_eq("t3_mul", 32'(multipla), 32'd1);
        hold(4'h0, 1'b1, 8);
        check_eq("t3_db", 32'(db_estado), 32'd0);

        // 4: bouncing release
        pulses = 0;
        hold(4'b0001, 1'b1, 12);
        for (int i = 0; i < 5; i++) hold((i % 2 == 0) ? 4'h0 : 4'b0001, 1'b1, 2);
        hold(4'h0, 1'b1, 10);
        check_eq("t4_pulses", 32'(pulses), 32'd1);
        check_eq("t4_db", 32'(db_estado), 32'd0);

        // 5: presses blocked while disabled
        pulses = 0;
        hold(4'b0001, 1'b0, 20);
        check_eq("t5_pulses_off", 32'(pulses), 32'd0);
        check_eq("t5_db_off", 32'(db_estado), 32'd0);
        hold(4'b0001, 1'b1, 12);
        check_eq("t5_pulses_on", 32'(pulses), 32'd1);
        hold(4'h0, 1'b1, 10);

        // 6: reset mid-filter, zera, zera colliding with a pulse
        pulses = 0;
        hold(4'b0100, 1'b1, 4);
        step(4'b0100, 1'b1, 1'b0, 1'b1);
        check_eq("t6_db_rst", 32'(db_estado), 32'd0);
        check_eq("t6_jog_rst", 32'(jogada), 32'd0);
        hold(4'b0100, 1'b1, 12);
        hold(4'h0, 1'b1, 10);
        check_eq("t6_reg", 32'(botoes_reg), 32'b0100);
        step(4'h0, 1'b1, 1'b1, 1'b0);
        check_eq("t6_zera_reg", 32'(botoes_reg), 32'd0);
        check_eq("t6_zera_mul", 32'(multipla), 32'd0);
        for (int i = 0; i < 8; i++) step(4'b0110, 1'b1, 1'b1, 1'b0);
        check_eq("t6_zera_pulso", 32'(botoes_reg), 32'b0110);
        hold(4'b0110, 1'b1, 4);
        hold(4'h0, 1'b1, 10);

        // Randomized segments against the model
        for (int i = 0; i < 400; i++) begin
            rb   = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            rh   = ($urandom_range(0, 7) != 0);
            rlen = $urandom_range(1, 10);
            for (int j = 0; j < rlen; j++)
                step(rb, rh, ($urandom_range(0, 15) == 0), ($urandom_range(0, 299) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
